// File: rtl/clock_div_bank.sv
// Bank of independent 50%-duty clock dividers with double-buffered divisors.
// Divisor writes park in pending_div and go active at a wrap, disable or sync.
module clock_div_bank #(
   parameter int          NUM_CH      = 4,
   parameter int          CNT_W       = 25,
   parameter int unsigned DEFAULT_DIV = 24_999_999
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [3:0]        wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
   output logic              wr_ack,
   output logic              wr_err,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pend
);

   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

   logic wr_ok;
   assign wr_ok = ({28'd0, wr_ch} < 32'(NUM_CH));

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_ack <= wr_en && wr_ok;
         wr_err <= wr_en && !wr_ok;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] active_div;
      logic [CNT_W-1:0] pending_div;
      logic             pnd;
      logic             clk_q;
      logic             tick_q;
      logic             wrap;
      logic             hold;
      logic             wr_hit;

      assign wrap   = (cnt == active_div);
      assign hold   = sync || !en[c];
      assign wr_hit = wr_en && (wr_ch == 4'(c));

      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            cnt         <= '0;
            active_div  <= DEF;
            pending_div <= DEF;
            pnd         <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
         end else begin
            if (hold) begin
               cnt    <= '0;
               clk_q  <= 1'b0;
               tick_q <= 1'b0;
            end else if (wrap) begin
               cnt    <= '0;
               clk_q  <= ~clk_q;
               tick_q <= ~clk_q;
            end else begin
               cnt    <= cnt + 1'b1;
               tick_q <= 1'b0;
            end
            // transfer sees the pre-edge pending value; a same-cycle write re-arms it
            if ((hold || wrap) && pnd) begin
               active_div <= pending_div;
               pnd        <= 1'b0;
            end
            if (wr_hit) begin
               pending_div <= wr_div;
               pnd         <= 1'b1;
            end
         end
      end

      assign clk_out[c] = clk_q;
      assign tick[c]    = tick_q;
      assign pend[c]    = pnd;
   end

endmodule
